// File: rtl/stack_pkg.sv
// Shared definitions for the stack pointer unit.
//
// Contents:
//   op_e      - command opcodes; bit1 = jump control involved, bit0 = memory read
//   state_e   - FSM states of stack_pointer_unit
//   op_writes - true for opcodes that store to the stack (PUSH/CALL)
//   op_jumps  - true for opcodes that involve jump control (CALL/RET)
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    function automatic logic op_writes(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_jumps(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer unit: tracks a full-descending stack pointer and issues one
// memory access per accepted command. PUSH/CALL pre-decrement the pointer and
// write; POP/RET read at the pointer and post-increment. Commands that would
// overflow or underflow the stack are dropped and raise sticky error flags.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   cmd_valid  - command request
//   cmd_op     - PUSH=0, POP=1, CALL=2, RET=3
//   cmd_ready  - unit is idle and can accept a command
//   mem_valid  - memory access request, held until mem_ack
//   mem_addr   - access address
//   mem_we     - 1 = write (PUSH/CALL), 0 = read (POP/RET)
//   mem_jump   - cmd_op[1] of the access in flight
//   mem_ack    - memory access complete (ignored when idle)
//   sp         - current stack pointer
//   depth      - occupied entries
//   full/empty - depth == DEPTH / depth == 0
//   err_ovf    - sticky: push-type command while full
//   err_unf    - sticky: pop-type command while empty
//   err_clr    - clears both sticky flags; a same-cycle error set wins
//
// States:
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_ISSUE | mem_valid high, waiting for mem_ack
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] STACK_TOP    = 8'h3E,
    parameter logic [ADDR_W-1:0] STACK_BOTTOM = 8'h00,
    parameter int                WORD_BYTES   = 2,
    localparam int               DEPTH        = (int'(STACK_TOP) - int'(STACK_BOTTOM)) / WORD_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd_op,
    output logic                       cmd_ready,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic                       mem_jump,
    input  logic                       mem_ack,
    output logic [ADDR_W-1:0]          sp,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err_ovf,
    output logic                       err_unf,
    input  logic                       err_clr
);

    localparam int                 DEPTH_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0]  STEP      = ADDR_W'(WORD_BYTES);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    // Reject stack geometries that cannot be walked in whole words.
    generate
        if (((int'(STACK_TOP) - int'(STACK_BOTTOM)) % WORD_BYTES) != 0) begin : g_bad_step
            $error("stack_pointer_unit: STACK_TOP-STACK_BOTTOM must be a multiple of WORD_BYTES");
        end
        if (int'(STACK_TOP) <= int'(STACK_BOTTOM)) begin : g_bad_range
            $error("stack_pointer_unit: STACK_TOP must be above STACK_BOTTOM");
        end
        if (WORD_BYTES <= 0) begin : g_bad_word
            $error("stack_pointer_unit: WORD_BYTES must be positive");
        end
    endgenerate

    state_e            state;
    op_e               op;
    logic [ADDR_W-1:0] sp_dec;
    logic [ADDR_W-1:0] sp_inc;
    logic              room_below;
    logic              room_above;
    logic              push_ok;
    logic              pop_ok;

    assign op     = op_e'(cmd_op);
    assign sp_dec = sp - STEP;
    assign sp_inc = sp + STEP;

    // Distance-based checks: the subtractions cannot wrap while sp stays
    // inside [STACK_BOTTOM, STACK_TOP], so the pointer never leaves that range
    // even if depth and sp were somehow to disagree.
    assign room_below = (sp - STACK_BOTTOM) >= STEP;
    assign room_above = (STACK_TOP - sp) >= STEP;
    assign push_ok    = !full && room_below;
    assign pop_ok     = !empty && room_above;

    assign full      = (depth == DEPTH_MAX);
    assign empty     = (depth == '0);
    assign cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sp        <= STACK_TOP;
            depth     <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= STACK_TOP;
            mem_we    <= 1'b0;
            mem_jump  <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            // Clear first so an error raised below in the same cycle wins.
            if (err_clr) begin
                err_ovf <= 1'b0;
                err_unf <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (op_writes(op)) begin
                            if (push_ok) begin
                                sp        <= sp_dec;
                                mem_addr  <= sp_dec;
                                mem_we    <= 1'b1;
                                mem_jump  <= op_jumps(op);
                                mem_valid <= 1'b1;
                                depth     <= depth + DEPTH_ONE;
                                state     <= ST_ISSUE;
                            end else begin
                                err_ovf <= 1'b1;
                            end
                        end else begin
                            if (pop_ok) begin
                                sp        <= sp_inc;
                                mem_addr  <= sp;
                                mem_we    <= 1'b0;
                                mem_jump  <= op_jumps(op);
                                mem_valid <= 1'b1;
                                depth     <= depth - DEPTH_ONE;
                                state     <= ST_ISSUE;
                            end else begin
                                err_unf <= 1'b1;
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    mem_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit with default parameters.
module tb_stack_pointer_unit;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready;
    logic       mem_valid;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic       mem_jump;
    logic       mem_ack = 1'b0;
    logic [7:0] sp;
    logic [4:0] depth;
    logic       full;
    logic       empty;
    logic       err_ovf;
    logic       err_unf;
    logic       err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stack_pointer_unit dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_jump  (mem_jump),
        .mem_ack   (mem_ack),
        .sp        (sp),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_clr   (err_clr)
    );

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] op;
        logic       ack;
        logic       clr;
        logic [7:0] e_sp;
        logic [4:0] e_depth;
        logic       e_mv;
        logic [7:0] e_addr;
        logic       e_we;
        logic       e_jmp;
        logic       e_rdy;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic a, input logic c);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        mem_ack   = a;
        err_clr   = c;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".sp"},        32'(sp),        32'(e.e_sp));
        chk({tag, ".depth"},     32'(depth),     32'(e.e_depth));
        chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(e.e_mv));
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e.e_addr));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(e.e_we));
        chk({tag, ".mem_jump"},  32'(mem_jump),  32'(e.e_jmp));
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(e.e_rdy));
        chk({tag, ".full"},      32'(full),      32'(e.e_full));
        chk({tag, ".empty"},     32'(empty),     32'(e.e_empty));
        chk({tag, ".err_ovf"},   32'(err_ovf),   32'(e.e_ovf));
        chk({tag, ".err_unf"},   32'(err_unf),   32'(e.e_unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int mv_cnt;
        logic [7:0] exp_addr;

        //            rst v  op       ack clr   sp     d  mv addr   we j  rdy f  e  ovf unf
        vecs[0]  = '{1, 0, OP_PUSH, 0, 0,   8'h3E, 0, 0, 8'h3E, 0, 0, 1, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, OP_PUSH, 0, 0,   8'h3C, 1, 1, 8'h3C, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, OP_POP,  0, 0,   8'h3C, 1, 1, 8'h3C, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, OP_PUSH, 1, 0,   8'h3C, 1, 0, 8'h3C, 1, 0, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, OP_PUSH, 0, 0,   8'h3A, 2, 1, 8'h3A, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, OP_PUSH, 1, 0,   8'h3A, 2, 0, 8'h3A, 1, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, OP_POP,  0, 0,   8'h3C, 1, 1, 8'h3A, 0, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, OP_PUSH, 1, 0,   8'h3C, 1, 0, 8'h3A, 0, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, OP_PUSH, 1, 0,   8'h3C, 1, 0, 8'h3A, 0, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, OP_CALL, 0, 0,   8'h3A, 2, 1, 8'h3A, 1, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, OP_PUSH, 1, 0,   8'h3A, 2, 0, 8'h3A, 1, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{0, 1, OP_RET,  0, 0,   8'h3C, 1, 1, 8'h3A, 0, 1, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 0, OP_PUSH, 1, 0,   8'h3C, 1, 0, 8'h3A, 0, 1, 1, 0, 0, 0, 0};
        vecs[13] = '{0, 1, OP_POP,  0, 0,   8'h3E, 0, 1, 8'h3C, 0, 0, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 0, OP_PUSH, 1, 0,   8'h3E, 0, 0, 8'h3C, 0, 0, 1, 0, 1, 0, 0};
        vecs[15] = '{0, 1, OP_RET,  0, 0,   8'h3E, 0, 0, 8'h3C, 0, 0, 1, 0, 1, 0, 1};
        vecs[16] = '{0, 1, OP_RET,  0, 1,   8'h3E, 0, 0, 8'h3C, 0, 0, 1, 0, 1, 0, 1};
        vecs[17] = '{0, 0, OP_PUSH, 0, 1,   8'h3E, 0, 0, 8'h3C, 0, 0, 1, 0, 1, 0, 0};

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].op, vecs[i].ack, vecs[i].clr);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Fill to 31 entries, then overflow.
        drive(1, 0, OP_PUSH, 0, 0);
        tick();
        for (int i = 0; i < 31; i++) begin
            exp_addr = 8'(8'h3E - 2 * (i + 1));
            drive(0, 1, OP_PUSH, 0, 0);
            tick();
            chk($sformatf("fill%0d.mem_valid", i), 32'(mem_valid), 32'd1);
            chk($sformatf("fill%0d.mem_addr", i),  32'(mem_addr),  32'(exp_addr));
            drive(0, 0, OP_PUSH, 1, 0);
            tick();
            chk($sformatf("fill%0d.ack", i), 32'(mem_valid), 32'd0);
        end
        chk("full.sp",    32'(sp),    32'h00);
        chk("full.depth", 32'(depth), 32'd31);
        chk("full.full",  32'(full),  32'd1);
        drive(0, 1, OP_PUSH, 0, 0);
        tick();
        chk("ovf.mem_valid", 32'(mem_valid), 32'd0);
        chk("ovf.err_ovf",   32'(err_ovf),   32'd1);
        chk("ovf.sp",        32'(sp),        32'h00);
        chk("ovf.full",      32'(full),      32'd1);
        chk("ovf.cmd_ready", 32'(cmd_ready), 32'd1);
        drive(0, 1, OP_CALL, 0, 1);
        tick();
        chk("ovf_set_clr.err_ovf", 32'(err_ovf), 32'd1);
        chk("ovf_set_clr.sp",      32'(sp),      32'h00);
        drive(0, 0, OP_PUSH, 0, 1);
        tick();
        chk("ovf_clr.err_ovf", 32'(err_ovf), 32'd0);
        drive(0, 1, OP_POP, 0, 0);
        tick();
        chk("pop_full.mem_addr", 32'(mem_addr), 32'h00);
        chk("pop_full.sp",       32'(sp),       32'h02);
        chk("pop_full.full",     32'(full),     32'd0);
        drive(0, 0, OP_PUSH, 1, 0);
        tick();

        // CALL with the ack arriving on the 4th cycle of mem_valid; a PUSH
        // held on cmd_valid meanwhile must wait for the ack.
        drive(1, 0, OP_PUSH, 0, 0);
        tick();
        drive(0, 1, OP_CALL, 0, 0);
        tick();
        mv_cnt = 0;
        drive(0, 1, OP_PUSH, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (mem_valid === 1'b1) mv_cnt++;
            chk($sformatf("call_wait%0d.mem_jump", k),  32'(mem_jump),  32'd1);
            chk($sformatf("call_wait%0d.cmd_ready", k), 32'(cmd_ready), 32'd0);
            chk($sformatf("call_wait%0d.sp", k),        32'(sp),        32'h3C);
            if (k == 3) drive(0, 1, OP_PUSH, 1, 0);
            tick();
        end
        chk("call.mv_cycles",   32'(mv_cnt),    32'd4);
        chk("call_ack.mem_valid", 32'(mem_valid), 32'd0);
        chk("call_ack.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("call_ack.sp",        32'(sp),        32'h3C);
        drive(0, 1, OP_PUSH, 0, 0);
        tick();
        chk("held_push.mem_valid", 32'(mem_valid), 32'd1);
        chk("held_push.sp",        32'(sp),        32'h3A);
        chk("held_push.mem_jump",  32'(mem_jump),  32'd0);
        chk("held_push.depth",     32'(depth),     32'd2);

        // Reset during ISSUE with an ack pending.
        drive(1, 0, OP_PUSH, 1, 0);
        tick();
        chk("rst_issue.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_issue.sp",        32'(sp),        32'h3E);
        chk("rst_issue.depth",     32'(depth),     32'd0);
        chk("rst_issue.mem_addr",  32'(mem_addr),  32'h3E);
        drive(0, 0, OP_PUSH, 1, 0);
        tick();
        chk("post_rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("post_rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst.sp",        32'(sp),        32'h3E);
        drive(0, 0, OP_PUSH, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
